button_debounce_multi: RTL
==========================

Name: button_debounce_multi

Overview:
- N-channel, two-sided button debouncer for the game's input path. It sits between raw pad inputs and the game FSM.
- Each channel has:
  - a 2-FF synchronizer;
  - a symmetric stable-level filter, timed by a shared slow tick;
  - one-cycle press and release pulses;
  - long-press detection.
- It replaces the single-channel, press-only countdown stretcher.

Parameters:
- N_CH, 4, number of independent button channels.
- DEBOUNCE_TICKS, 15, consecutive mismatching ticks required to flip the stable level. Legal range is 1 or more.
- HOLD_TICKS, 64, ticks of continuous stable-high level before a long press is flagged. Legal range is 1 or more.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- countdown_en  input  1  shared timing tick, high for one clk cycle per sample period.
- button_in  input  N_CH  raw, asynchronous button levels; 1 = pressed.
- button_out  output  N_CH  debounced stable level per channel.
- press  output  N_CH  one-cycle pulse on a 0->1 stable transition.
- release  output  N_CH  one-cycle pulse on a 1->0 stable transition.
- long_press  output  N_CH  one-cycle pulse when the hold threshold is reached.
- held  output  N_CH  level; high from the long_press pulse until release.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, and has priority over everything else.
  - While reset is high, these are all cleared to 0: sync flops, debounce counter, hold counter, button_out, press, release, long_press, held.
  - Reset asserted mid-count discards the count.
  - A button held through reset is re-detected from zero after reset deasserts (full sync + debounce latency).
- Synchronizer: s1 <= button_in[i]; s2 <= s1. s2 is the only filtered input.
- Debounce counter:
  - Width is CW = clog2(DEBOUNCE_TICKS+1).
  - When s2 == button_out[i]: counter <= 0 on every clk, independent of the tick. Any matching sample restarts the filter.
  - When s2 != button_out[i] and countdown_en is high:
    - If counter == DEBOUNCE_TICKS-1: button_out[i] <= s2 and counter <= 0.
    - Otherwise counter increments.
  - When s2 != button_out[i] and countdown_en is low: counter holds.
  - The counter never exceeds DEBOUNCE_TICKS-1, so no wrap is possible.
- Edge pulses:
  - press[i] and release[i] are registered on the same edge that flips button_out[i]. The pulse is high in the first cycle the new level is visible and is low in all other cycles.
  - press and release are never simultaneously high on a channel.
- Latency: a clean step on button_in appears on button_out 2 clk (sync) plus DEBOUNCE_TICKS ticks later.
- Hold detection:
  - Hold counter width is HW = clog2(HOLD_TICKS+1).
  - While button_out[i] == 0, or on a release edge: hold counter <= 0 and held <= 0, on the same edge as the release.
  - While button_out[i] == 1, held == 0 and countdown_en is high:
    - If hold counter == HOLD_TICKS-1: held <= 1 and long_press <= 1 for one cycle.
    - Otherwise the hold counter increments.
  - The hold counter freezes once held is high. No auto-repeat.
  - The tick that flips button_out to 1 is not counted toward the hold.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- If countdown_en is stuck high, the timing is in clk cycles. This must be legal.

Decomposition:
- Shared package holds the default constants (DEBOUNCE_TICKS_DEF, HOLD_TICKS_DEF) and a width helper function for clog2-based widths.
- Natural sub-module: debounce_channel. It contains the sync, debounce and hold logic for one bit.
- The top level instantiates debounce_channel N_CH times with a generate loop and fans out countdown_en.

Test Plan:
- Reset, then idle: hold button_in=0 for 100 ticks -> all outputs 0.
- Ch0 step 0->1 with countdown_en every 4 clk and DEBOUNCE_TICKS=15 -> button_out[0] rises 2 clk + 15 ticks later, with a single-cycle press[0] in that cycle; no release.
- Ch1 bounce: alternate the input every 3 ticks for 30 ticks, then hold at 1 -> no press during the bounce; press[1] occurs exactly 15 ticks after the final stable edge (plus sync).
- Long press with HOLD_TICKS=64: hold ch2 high -> long_press[2] pulses once 64 ticks after press[2] and held[2]=1. Then release -> release[2] pulse, with held[2]=0 on the same edge.
- Reset mid-debounce: ch3 at count 10, then reset for 1 clk -> counters cleared and button_out[3]=0. The input still high re-presses after 2 clk + 15 ticks.
- Simultaneous: ch0 press and ch1 release resolving on the same tick -> press[0] and release[1] are high in the same cycle, and other channels are unaffected.

Source files
------------

// File: rtl/button_debounce_multi_pkg.sv
// Shared constants and width helper for the multi-channel button debouncer.
package button_debounce_multi_pkg;

  localparam int DEBOUNCE_TICKS_DEF = 15;
  localparam int HOLD_TICKS_DEF     = 64;

  // Bits needed to hold values 0..v (at least one bit).
  function automatic int cnt_width(input int v);
    if (v < 1) begin
      return 1;
    end else begin
      return $clog2(v + 1);
    end
  endfunction

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One button channel: 2-FF synchronizer, symmetric tick-timed level filter,
// press/release edge pulses and long-press (hold) detection.
module debounce_channel
  import button_debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int HOLD_TICKS     = HOLD_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic countdown_en,
  input  logic button_in,
  output logic button_out,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam int HW = cnt_width(HOLD_TICKS);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] DB_ONE    = CW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_next;
  logic          flip;
  logic          level_next;
  logic          press_next;
  logic          release_next;
  logic          long_next;
  logic          held_next;

  // Next-state for the level filter, edge pulses and hold tracking.
  always_comb begin
    flip      = 1'b0;
    cnt_next  = cnt;
    hcnt_next = hcnt;
    held_next = held;
    long_next = 1'b0;

    if (s2 == button_out) begin
      cnt_next = '0;
    end else if (countdown_en) begin
      if (cnt == DB_LAST) begin
        flip     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + DB_ONE;
      end
    end else begin
      cnt_next = cnt;
    end

    level_next   = flip ? s2 : button_out;
    press_next   = flip & s2;
    release_next = flip & ~s2;

    // The rising-flip tick is not counted: button_out is still 0 on that edge.
    if (!button_out || flip) begin
      hcnt_next = '0;
      held_next = 1'b0;
    end else if (!held && countdown_en) begin
      if (hcnt == HOLD_LAST) begin
        held_next = 1'b1;
        long_next = 1'b1;
      end else begin
        hcnt_next = hcnt + HOLD_ONE;
      end
    end else begin
      hcnt_next = hcnt;
    end
  end

  // State and output registers; reset clears everything including the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      hcnt          <= '0;
      button_out    <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      s1            <= button_in;
      s2            <= s1;
      cnt           <= cnt_next;
      hcnt          <= hcnt_next;
      button_out    <= level_next;
      press         <= press_next;
      release_pulse <= release_next;
      long_press    <= long_next;
      held          <= held_next;
    end
  end

endmodule

// File: rtl/button_debounce_multi.sv
// N independent debounce channels sharing one sample tick.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int HOLD_TICKS     = HOLD_TICKS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            countdown_en,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] button_out,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] held
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .countdown_en (countdown_en),
      .button_in    (button_in[i]),
      .button_out   (button_out[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .held         (held[i])
    );
  end

endmodule
